// File: rtl/i2so_bist_check.sv
// Sawtooth checker at the receive end of the I2S BIST stream: locks on the
// programmed start word, then checks left = sawtooth, right = ~left.
//
// state | meaning
// IDLE  | disarmed; counters and fail hold for readback
// SEEK  | armed, waiting for the start word to lock
// TRACK | locked, checking every strobed word
module i2so_bist_check #(
  parameter int LOCK_LOSS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rf_bist_chk_en,
  input  logic [11:0]      rf_bist_start_val,
  input  logic [11:0]      rf_bist_up_limit,
  input  logic [7:0]       rf_bist_inc,
  input  logic [31:0]      chk_in_data,
  input  logic             chk_in_xfc,
  output logic             bist_locked,
  output logic             bist_fail,
  output logic             bist_err_pulse,
  output logic [CNT_W-1:0] bist_word_cnt,
  output logic [CNT_W-1:0] bist_err_cnt
);

  typedef enum logic [1:0] {IDLE, SEEK, TRACK} state_t;

  localparam logic [3:0]       LOSS_N  = 4'(LOCK_LOSS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [15:0]      exp_q, exp_d;
  logic [3:0]       miss_q, miss_d;
  logic             fail_q, fail_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  logic [15:0] s_val, l_val, i_val, left, right;
  logic        start_hit, word_good;

  assign s_val = {rf_bist_start_val, 4'h0};
  assign l_val = {rf_bist_up_limit, 4'h0};
  assign i_val = {4'h0, rf_bist_inc, 4'h0};
  assign left  = chk_in_data[15:0];
  assign right = chk_in_data[31:16];

  assign start_hit = (left == s_val) && (right == ~s_val);
  assign word_good = (left == exp_q) && (right == ~exp_q);

  // Signed compare against the limit; the add wraps mod 2^16 on purpose.
  function automatic logic [15:0] saw_next(input logic [15:0] x);
    return ($signed(x) >= $signed(l_val)) ? s_val : x + i_val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      miss_q  <= '0;
      fail_q  <= 1'b0;
      pulse_q <= 1'b0;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      miss_q  <= miss_d;
      fail_q  <= fail_d;
      pulse_q <= pulse_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    miss_d  = miss_q;
    fail_d  = fail_q;
    pulse_d = 1'b0;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    if (!rf_bist_chk_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Arming cycle clears results; a word strobed now is not used.
          state_d = SEEK;
          fail_d  = 1'b0;
          wcnt_d  = '0;
          ecnt_d  = '0;
          miss_d  = '0;
        end
        SEEK: begin
          if (chk_in_xfc && start_hit) begin
            state_d = TRACK;
            exp_d   = saw_next(s_val);
          end
        end
        TRACK: begin
          if (chk_in_xfc) begin
            wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + CNT_ONE;
            exp_d  = saw_next(exp_q);
            if (word_good) begin
              miss_d = '0;
            end else begin
              ecnt_d  = (&ecnt_q) ? ecnt_q : ecnt_q + CNT_ONE;
              pulse_d = 1'b1;
              fail_d  = 1'b1;
              if (miss_q + 4'd1 >= LOSS_N) begin
                state_d = SEEK;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 4'd1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bist_locked    = (state_q == TRACK);
  assign bist_fail      = fail_q;
  assign bist_err_pulse = pulse_q;
  assign bist_word_cnt  = wcnt_q;
  assign bist_err_cnt   = ecnt_q;

endmodule

// File: tb/tb_i2so_bist_check.sv
// Directed bench for i2so_bist_check: sawtooth lock, errors, lock loss,
// 16-bit wrap, reset mid-track, disarm/re-arm, constant stream.
module tb_i2so_bist_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_bist_chk_en;
  logic [11:0] rf_bist_start_val;
  logic [11:0] rf_bist_up_limit;
  logic [7:0]  rf_bist_inc;
  logic [31:0] chk_in_data;
  logic        chk_in_xfc;
  logic        bist_locked;
  logic        bist_fail;
  logic        bist_err_pulse;
  logic [15:0] bist_word_cnt;
  logic [15:0] bist_err_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] m_exp;

  always #5 clk = ~clk;

  i2so_bist_check #(.LOCK_LOSS(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .rf_bist_chk_en   (rf_bist_chk_en),
    .rf_bist_start_val(rf_bist_start_val),
    .rf_bist_up_limit (rf_bist_up_limit),
    .rf_bist_inc      (rf_bist_inc),
    .chk_in_data      (chk_in_data),
    .chk_in_xfc       (chk_in_xfc),
    .bist_locked      (bist_locked),
    .bist_fail        (bist_fail),
    .bist_err_pulse   (bist_err_pulse),
    .bist_word_cnt    (bist_word_cnt),
    .bist_err_cnt     (bist_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] s16();
    return {rf_bist_start_val, 4'h0};
  endfunction

  // Independent reference for the sawtooth step.
  function automatic logic [15:0] nxt(input logic [15:0] x);
    logic [15:0] l, i;
    l = {rf_bist_up_limit, 4'h0};
    i = {4'h0, rf_bist_inc, 4'h0};
    if ($signed(x) >= $signed(l)) return s16();
    return x + i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    chk_in_data = {r, l};
    chk_in_xfc  = 1'b1;
    tick();
    chk_in_xfc  = 1'b0;
  endtask

  task automatic send_good(input int n);
    for (int k = 0; k < n; k++) begin
      send(m_exp, ~m_exp);
      m_exp = nxt(m_exp);
    end
  endtask

  task automatic send_bad();
    send(m_exp, m_exp);
    m_exp = nxt(m_exp);
  endtask

  task automatic lock();
    send(s16(), ~s16());
    m_exp = nxt(s16());
  endtask

  task automatic rearm();
    rf_bist_chk_en = 1'b0;
    tick();
    rf_bist_chk_en = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; rf_bist_chk_en = 1'b0; chk_in_xfc = 1'b0; chk_in_data = '0;
    rf_bist_start_val = 12'h010; rf_bist_inc = 8'h01; rf_bist_up_limit = 12'h014;
    m_exp = '0;
    tick(); tick();
    chk("rst_locked", 32'(bist_locked), 0);
    chk("rst_fail", 32'(bist_fail), 0);
    chk("rst_wcnt", 32'(bist_word_cnt), 0);
    chk("rst_ecnt", 32'(bist_err_cnt), 0);
    rst = 1'b0;

    // 1: ideal stream
    rf_bist_chk_en = 1'b1;
    tick();
    send(16'h1234, 16'hEDCB);
    chk("t1_seek_unlocked", 32'(bist_locked), 0);
    lock();
    chk("t1_locked", 32'(bist_locked), 1);
    chk("t1_lock_wcnt", 32'(bist_word_cnt), 0);
    send_good(20);
    chk("t1_locked_end", 32'(bist_locked), 1);
    chk("t1_wcnt", 32'(bist_word_cnt), 20);
    chk("t1_ecnt", 32'(bist_err_cnt), 0);
    chk("t1_fail", 32'(bist_fail), 0);

    // 2: single corrupt right channel
    rearm();
    lock();
    send_good(4);
    send(m_exp, ~m_exp ^ 16'h0001);
    m_exp = nxt(m_exp);
    chk("t2_pulse", 32'(bist_err_pulse), 1);
    chk("t2_ecnt", 32'(bist_err_cnt), 1);
    chk("t2_fail", 32'(bist_fail), 1);
    chk("t2_locked", 32'(bist_locked), 1);
    tick();
    chk("t2_pulse_off", 32'(bist_err_pulse), 0);
    send_good(10);
    chk("t2_ecnt_end", 32'(bist_err_cnt), 1);
    chk("t2_wcnt_end", 32'(bist_word_cnt), 15);

    // 3: lock loss after four bad words
    rearm();
    chk("t3_rearm_fail", 32'(bist_fail), 0);
    lock();
    send_good(3);
    send_bad(); send_bad(); send_bad();
    chk("t3_locked_3bad", 32'(bist_locked), 1);
    send_bad();
    chk("t3_unlocked", 32'(bist_locked), 0);
    chk("t3_ecnt", 32'(bist_err_cnt), 4);
    chk("t3_wcnt", 32'(bist_word_cnt), 7);
    send(16'h0110, 16'hFEEF);
    send(16'hAAAA, 16'h0000);
    chk("t3_seek_ecnt", 32'(bist_err_cnt), 4);
    chk("t3_seek_unlocked", 32'(bist_locked), 0);
    send(16'h0100, 16'hFEFF);
    m_exp = 16'h0110;
    chk("t3_relock", 32'(bist_locked), 1);
    send_good(2);
    chk("t3_ecnt_end", 32'(bist_err_cnt), 4);
    chk("t3_wcnt_end", 32'(bist_word_cnt), 9);

    // 4: 16-bit wrap path
    rf_bist_chk_en = 1'b0; tick();
    rf_bist_start_val = 12'h7F0; rf_bist_inc = 8'h20; rf_bist_up_limit = 12'h7FF;
    rf_bist_chk_en = 1'b1; tick();
    send(16'h7F00, 16'h80FF);
    m_exp = 16'h8100;
    chk("t4_locked", 32'(bist_locked), 1);
    send_good(140);
    chk("t4_ecnt", 32'(bist_err_cnt), 0);
    chk("t4_wcnt", 32'(bist_word_cnt), 140);
    chk("t4_locked_end", 32'(bist_locked), 1);

    // 5: reset mid-track
    send_bad();
    chk("t5_pre_fail", 32'(bist_fail), 1);
    rst = 1'b1;
    tick();
    chk("t5_locked", 32'(bist_locked), 0);
    chk("t5_fail", 32'(bist_fail), 0);
    chk("t5_pulse", 32'(bist_err_pulse), 0);
    chk("t5_wcnt", 32'(bist_word_cnt), 0);
    chk("t5_ecnt", 32'(bist_err_cnt), 0);
    rst = 1'b0;
    tick();
    lock();
    chk("t5_relock", 32'(bist_locked), 1);

    // 6: disarm with a word in the same cycle, then re-arm
    send_good(3);
    send_bad();
    rf_bist_chk_en = 1'b0;
    send_bad();
    chk("t6_idle_unlocked", 32'(bist_locked), 0);
    chk("t6_idle_pulse", 32'(bist_err_pulse), 0);
    chk("t6_idle_ecnt", 32'(bist_err_cnt), 1);
    chk("t6_idle_wcnt", 32'(bist_word_cnt), 4);
    send(s16(), ~s16());
    tick(); tick();
    chk("t6_hold_wcnt", 32'(bist_word_cnt), 4);
    chk("t6_hold_fail", 32'(bist_fail), 1);
    rf_bist_chk_en = 1'b1;
    send(s16(), ~s16());
    chk("t6_arm_wcnt", 32'(bist_word_cnt), 0);
    chk("t6_arm_ecnt", 32'(bist_err_cnt), 0);
    chk("t6_arm_fail", 32'(bist_fail), 0);
    chk("t6_arm_nolock", 32'(bist_locked), 0);

    // 7: start >= limit gives a constant stream
    rf_bist_chk_en = 1'b0; tick();
    rf_bist_start_val = 12'h020; rf_bist_inc = 8'h05; rf_bist_up_limit = 12'h010;
    rf_bist_chk_en = 1'b1; tick();
    lock();
    chk("t7_exp_const", 32'(m_exp), 32'h0200);
    send(16'h0200, 16'hFDFF);
    send(16'h0200, 16'hFDFF);
    send(16'h0200, 16'hFDFF);
    chk("t7_ecnt", 32'(bist_err_cnt), 0);
    chk("t7_wcnt", 32'(bist_word_cnt), 3);
    chk("t7_locked", 32'(bist_locked), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
